dma_copy_master: RTL
====================

// Module: dma_copy_master
// PURPOSE
//  Bus initiator (master end of the slave bus protocol) that copies LEN 32-bit words from SRC to DST.
//  Each word is one READ transfer followed by one WRITE transfer on a single shared bus port.
//  Sits beside the core on the interconnect; software programs it through the cfg_* ports.
//  Intended targets are the dual-port memory and peripherals; any slave that honours ss/ttype/bdone works.
// PARAMETERS
//  ADDR_W    32    bus address width
//  LEN_W     16    word-count width; max copy length is 2**LEN_W-1 words
//  TIMEOUT   255   max cycles to wait for bdone per transfer before abort; 0 disables the timeout
// PORTS
//  clk            in   1       system clock, all logic on rising edge
//  rst_n          in   1       asynchronous active-low reset
//  cfg_start      in   1       1-cycle pulse; latches cfg_src, cfg_dst and cfg_len when idle
//  cfg_src        in   ADDR_W  source byte address; must be word aligned
//  cfg_dst        in   ADDR_W  destination byte address; must be word aligned
//  cfg_len        in   LEN_W   number of words to copy
//  busy           out  1       high from the cycle after an accepted start until done or err
//  done           out  1       1-cycle pulse on successful completion
//  err            out  1       1-cycle pulse on misalignment or timeout abort
//  words_left     out  LEN_W   words still to copy
//  bus.ss         out  1       transfer request, held until bdone
//  bus.ttype      out  enum    READ or WRITE
//  bus.addr       out  ADDR_W  transfer address
//  bus.wdata      out  32      write data
//  bus.tsize      out  2       always WORD (2'b10)
//  bus.rdata      in   32      read data, valid when bdone=1 during READ
//  bus.bdone      in   1       slave completion; may be high in the same cycle ss rises
// BEHAVIOUR
//  Reset (async, rst_n=0): state=IDLE.
//   Outputs: busy=0, done=0, err=0, words_left=0, ss=0, ttype=READ, addr=0, wdata=0, tsize=WORD.
//   All counters and pointers clear. Reset mid-transfer drops ss immediately; the partial copy is not resumed.
//  States: IDLE, RD, WR, FIN, ABORT.
//  IDLE:
//   - cfg_start=1 with (cfg_src|cfg_dst)[1:0]!=0 -> ABORT.
//   - cfg_start=1 with cfg_len==0 -> FIN.
//   - cfg_start=1 otherwise -> RD; latch src_ptr, dst_ptr and words_left=cfg_len.
//   - cfg_start is ignored in every state other than IDLE.
//  RD:
//   - ss=1, ttype=READ, addr=src_ptr.
//   - On bdone=1: buf<=rdata, then -> WR.
//  WR:
//   - ss=1, ttype=WRITE, addr=dst_ptr, wdata=buf.
//   - On bdone=1: src_ptr+=4, dst_ptr+=4, words_left-=1.
//   - Then -> FIN if words_left was 1, else -> RD.
//  FIN: done=1 for one cycle -> IDLE.
//  ABORT: err=1 for one cycle -> IDLE; words_left keeps its value at the abort.
//  busy=1 in RD and WR only; done and err are never high together.
//  Zero-wait slave (bdone tied high): exactly 2 cycles per word, so start-to-done = 2*LEN+1 cycles.
//  ss deasserts for at most 0 cycles between back-to-back transfers; ttype and addr change on the bdone edge.
//  Timeout: wait counter clears on entering RD/WR and counts cycles with ss=1 and bdone=0.
//   Reaching TIMEOUT -> ABORT and ss drops next cycle.
//  Pointer increments wrap modulo 2**ADDR_W with no error.
//  Overlapping src/dst regions are copied strictly in ascending order; no hazard detection.
// TESTING
//  1. Zero-wait memory holds 0x11,0x22,0x33 at 0x100; start src=0x100 dst=0x200 len=3
//     -> words 0x200..0x208 = 0x11,0x22,0x33; done 7 cycles after start; busy high 6 cycles.
//  2. len=0 start -> done pulse next cycle; no ss asserted; busy stays 0.
//  3. src=0x102 -> err pulse next cycle; no bus activity; a later aligned start works normally.
//  4. Slave bdone delayed 3 cycles each transfer, len=2
//     -> ss held steady through the waits; data correct; done after 2*2*4+1 cycles.
//  5. TIMEOUT=8, slave never asserts bdone -> err pulse after 8 wait cycles; words_left=len.
//  6. rst_n low during WR of word 2 of 4 -> all outputs return to reset values immediately.
//     After release, a new start of len=1 completes in 3 cycles.

Source files
------------

// File: rtl/dma_copy_master_if.sv
// Shared single-port bus between the copy master and a memory-mapped slave.
// ttype encodes READ as 0 and WRITE as 1; tsize 2'b10 means a 32-bit word.
interface dma_copy_master_if #(
  parameter int unsigned ADDR_W = 32
);
  logic              ss;
  logic              ttype;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic [1:0]        tsize;
  logic [31:0]       rdata;
  logic              bdone;

  modport master (
    output ss, ttype, addr, wdata, tsize,
    input  rdata, bdone
  );

  modport slave (
    input  ss, ttype, addr, wdata, tsize,
    output rdata, bdone
  );
endinterface

// File: rtl/dma_copy_master.sv
// Word-by-word memory copy engine: each word is one READ transfer followed by
// one WRITE transfer on a shared bus port, with an optional per-transfer timeout.
module dma_copy_master #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned LEN_W   = 16,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_start,
  input  logic [ADDR_W-1:0] cfg_src,
  input  logic [ADDR_W-1:0] cfg_dst,
  input  logic [LEN_W-1:0]  cfg_len,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [LEN_W-1:0]  words_left,
  dma_copy_master_if.master bus
);

  localparam logic TtRead  = 1'b0;
  localparam logic TtWrite = 1'b1;
  localparam int unsigned WaitW = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WaitW-1:0] WaitLast = (TIMEOUT > 0) ? WaitW'(TIMEOUT - 1) : '0;

  typedef enum logic [2:0] {StIdle, StRd, StWr, StFin, StAbort} state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] src_q, dst_q, addr_q;
  logic [31:0]       wdata_q;
  logic [WaitW-1:0]  wait_q;
  logic              ss_q, ttype_q;
  logic              timeout_hit;

  // The transfer in flight has already waited TIMEOUT-1 cycles and is stalled again.
  assign timeout_hit = (TIMEOUT != 0) && !bus.bdone && (wait_q == WaitLast);

  assign bus.ss    = ss_q;
  assign bus.ttype = ttype_q;
  assign bus.addr  = addr_q;
  assign bus.wdata = wdata_q;
  assign bus.tsize = 2'b10;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      src_q      <= '0;
      dst_q      <= '0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wait_q     <= '0;
      ss_q       <= 1'b0;
      ttype_q    <= TtRead;
      busy       <= 1'b0;
      done       <= 1'b0;
      err        <= 1'b0;
      words_left <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (cfg_start) begin
            if ((cfg_src[1:0] | cfg_dst[1:0]) != 2'b00) begin
              state_q <= StAbort;
              err     <= 1'b1;
            end else if (cfg_len == '0) begin
              state_q <= StFin;
              done    <= 1'b1;
            end else begin
              state_q    <= StRd;
              busy       <= 1'b1;
              ss_q       <= 1'b1;
              ttype_q    <= TtRead;
              addr_q     <= cfg_src;
              src_q      <= cfg_src;
              dst_q      <= cfg_dst;
              words_left <= cfg_len;
              wait_q     <= '0;
            end
          end
        end
        StRd, StWr: begin
          if (bus.bdone) begin
            wait_q <= '0;
            if (state_q == StRd) begin
              wdata_q <= bus.rdata;
              state_q <= StWr;
              ttype_q <= TtWrite;
              addr_q  <= dst_q;
            end else begin
              src_q      <= src_q + ADDR_W'(4);
              dst_q      <= dst_q + ADDR_W'(4);
              words_left <= words_left - LEN_W'(1);
              ttype_q    <= TtRead;
              if (words_left == LEN_W'(1)) begin
                state_q <= StFin;
                done    <= 1'b1;
                busy    <= 1'b0;
                ss_q    <= 1'b0;
              end else begin
                state_q <= StRd;
                addr_q  <= src_q + ADDR_W'(4);
              end
            end
          end else if (timeout_hit) begin
            state_q <= StAbort;
            err     <= 1'b1;
            busy    <= 1'b0;
            ss_q    <= 1'b0;
            ttype_q <= TtRead;
          end else begin
            wait_q <= wait_q + WaitW'(1);
          end
        end
        StFin, StAbort: state_q <= StIdle;
        default:        state_q <= StIdle;
      endcase
    end
  end

endmodule
